// File: rtl/cpu_pkg.sv
// cpu_pkg: shared port indices, arbiter FSM states and default widths
// Contents: PORT_FETCH/PORT_DATA indices, arb_state_t, N_DEF/AW_DEF defaults
package cpu_pkg;
    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;
    localparam int N_DEF      = 16;
    localparam int AW_DEF     = 12;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational 2-way winner picker for the memory arbiter
// Ports: req_i   request vector (bit0 fetch, bit1 data)
//        last_i  last-granted pointer (1 = data granted last)
//        gnt_o   one-hot winner, zero when no request
// Config: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break, else data wins ties
module mem_arb_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time takes the slot
    assign gnt_o = (&req_i) ? (last_i ? 2'b01 : 2'b10) : req_i;
`else
    logic unused_last;
    assign unused_last = last_i;
    assign gnt_o = req_i[1] ? 2'b10 : req_i;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between fetch and load/store
// Ports: clk, rst (sync active-high)
//        fetch_req_i/fetch_addr_i/fetch_done_o         instruction-fetch requester
//        data_req_i/data_we_i/data_addr_i/data_wdata_i/data_done_o   load/store requester
//        rdata_o  read data, valid with a done pulse; grant_o one-hot owner; busy_o not idle
//        mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i   memory side
// Config: MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-break (default: data over fetch)
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req_i,
    input  logic [AW-1:0] fetch_addr_i,
    output logic          fetch_done_o,
    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [N-1:0]  data_wdata_i,
    output logic          data_done_o,
    output logic [N-1:0]  rdata_o,
    output logic [1:0]    grant_o,
    output logic          busy_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [N-1:0]  mem_wdata_o,
    input  logic [N-1:0]  mem_rdata_i
);
    arb_state_t    state_q, state_d;
    logic [1:0]    req, pick, grant_q, done_q;
    logic          start, last;
    logic          en_q, we_q, busy_q;
    logic [AW-1:0] addr_q;
    logic [N-1:0]  wdata_q, rdata_q;

    assign req   = {data_req_i, fetch_req_i};
    assign start = (state_q == IDLE) && |req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_d = start ? pick[PORT_DATA] : last_q;
    assign last   = last_q;
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`else
    assign last = 1'b1;
`endif

    mem_arb_pick u_pick (
        .req_i  (req),
        .last_i (last),
        .gnt_o  (pick)
    );

    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE)  ? (start ? ISSUE : IDLE) :
                  (state_q == ISSUE) ? WAIT :
                  (state_q == WAIT)  ? DONE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= start;
            busy_q  <= state_d != IDLE;
            done_q  <= (state_q == WAIT) ? grant_q : 2'b00;
            grant_q <= start ? pick : (state_q == DONE) ? 2'b00 : grant_q;
            if (start) begin
                we_q    <= pick[PORT_DATA] & data_we_i;
                addr_q  <= pick[PORT_DATA] ? data_addr_i : fetch_addr_i;
                wdata_q <= pick[PORT_DATA] ? data_wdata_i : '0;
            end
            if (state_q == WAIT) rdata_q <= mem_rdata_i;
        end
    end

    // Write enable is decoded from state so a reset cycle can veto the write at once
    assign mem_we_o     = (state_q == ISSUE) & we_q & ~rst;
    assign mem_en_o     = en_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign rdata_o      = rdata_q;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
    assign fetch_done_o = done_q[PORT_FETCH];
    assign data_done_o  = done_q[PORT_DATA];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a memory model and transaction-level reference
module tb_mem_arbiter;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_i, data_req_i, data_we_i;
    logic [11:0] fetch_addr_i, data_addr_i;
    logic [15:0] data_wdata_i;
    logic        fetch_done_o, data_done_o, busy_o, mem_en_o, mem_we_o;
    logic [15:0] rdata_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]  grant_o;
    logic [11:0] mem_addr_o;

    logic [15:0] mem [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic        preload;
    int          we_cnt = 0;
    int          vectors = 0, errors = 0;
    int          last_port = PORT_DATA;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_done_o(fetch_done_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_done_o(data_done_o),
        .rdata_o(rdata_o), .grant_o(grant_o), .busy_o(busy_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
            mem[0]      <= 16'h1111;
            mem[1]      <= 16'h2222;
            mem[12'h10] <= 16'hBEEF;
        end else if (mem_en_o) begin
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
            mem_rdata_i <= mem[mem_addr_o];
        end
    end

    always @(posedge clk) if (mem_we_o) we_cnt <= we_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic fr, input logic dr);
        if (fr && dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (last_port == PORT_DATA) ? PORT_FETCH : PORT_DATA;
`else
            return PORT_DATA;
`endif
        end
        return dr ? PORT_DATA : PORT_FETCH;
    endfunction

    task automatic txn(input logic fr, input logic [11:0] fa, input logic dr, input logic we,
                       input logic [11:0] da, input logic [15:0] wd,
                       input int port, input logic chk_rd, input logic [15:0] rd);
        int   n, w0;
        logic st;
        st = (port == PORT_DATA) && we;
        w0 = we_cnt;
        fetch_req_i = fr; fetch_addr_i = fa;
        data_req_i = dr; data_we_i = we; data_addr_i = da; data_wdata_i = wd;
        @(negedge clk);
        chk("issue_en", 32'(mem_en_o), 1);
        chk("issue_grant", 32'(grant_o), 32'(1 << port));
        chk("issue_addr", 32'(mem_addr_o), 32'(port == PORT_DATA ? da : fa));
        n = 0;
        while (!(fetch_done_o || data_done_o) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", 32'(n), 2);
        chk("done_port", 32'({data_done_o, fetch_done_o}), 32'(1 << port));
        if (chk_rd) chk("rdata", 32'(rdata_o), 32'(rd));
        fetch_req_i = 1'b0; data_req_i = 1'b0;
        @(negedge clk);
        chk("idle_after", 32'({busy_o, fetch_done_o, data_done_o, grant_o}), 0);
        chk("we_cycles", 32'(we_cnt - w0), st ? 1 : 0);
        if (st) ref_mem[da] = wd;
    endtask

    task automatic model_txn(input logic fr, input logic [11:0] fa, input logic dr, input logic we,
                             input logic [11:0] da, input logic [15:0] wd);
        int          e;
        logic [15:0] rd;
        e  = model_pick(fr, dr);
        rd = (e == PORT_DATA) ? ref_mem[da] : ref_mem[fa];
        txn(fr, fa, dr, we, da, wd, e, !(e == PORT_DATA && we), rd);
        last_port = e;
    endtask

    typedef struct {
        logic        fr;
        logic [11:0] fa;
        logic        dr;
        logic        we;
        logic [11:0] da;
        logic [15:0] wd;
        int          port;
        logic        chk_rd;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, d, w0, n;
        tbl[0] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 16'h0000, PORT_DATA,  1'b1, 16'hBEEF};
        tbl[1] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 16'h1234, PORT_DATA,  1'b0, 16'h0000};
        tbl[2] = '{1'b1, 12'h020, 1'b0, 1'b0, 12'h000, 16'h0000, PORT_FETCH, 1'b1, 16'h1234};
        tbl[3] = '{1'b1, 12'h000, 1'b1, 1'b0, 12'h001, 16'h0000, PORT_DATA,  1'b1, 16'h2222};
        tbl[4] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 16'h5A5A, PORT_DATA,  1'b0, 16'h0000};
        tbl[5] = '{1'b1, 12'h001, 1'b0, 1'b0, 12'h000, 16'h0000, PORT_FETCH, 1'b1, 16'h5A5A};
        tbl[6] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h0FF, 16'h0000, PORT_DATA,  1'b1, 16'hA55A};
        tbl[7] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 12'h000, 16'h0000, PORT_FETCH, 1'b1, 16'hAA5A};
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'(i) ^ 16'hA5A5;
        ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[12'h10] = 16'hBEEF;

        rst = 1'b1; preload = 1'b1;
        fetch_req_i = 1'b1; fetch_addr_i = 12'h000;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 12'h010; data_wdata_i = 16'h0000;
        @(negedge clk);
        preload = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("rst_ctl", 32'({fetch_done_o, data_done_o, grant_o, busy_o, mem_en_o, mem_we_o}), 0);
            chk("rst_data", 32'({rdata_o, mem_wdata_o}), 0);
            chk("rst_addr", 32'(mem_addr_o), 0);
            @(negedge clk);
        end
        rst = 1'b0;
        model_txn(1'b1, 12'h000, 1'b1, 1'b0, 12'h010, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].we, tbl[i].da, tbl[i].wd,
                tbl[i].port, tbl[i].chk_rd, tbl[i].rd);
            last_port = tbl[i].port;
        end

        fetch_req_i = 1'b1; fetch_addr_i = 12'h002;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 12'h003;
        k = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (fetch_done_o || data_done_o) begin
                d = model_pick(1'b1, 1'b1);
                chk("contend_port", 32'({data_done_o, fetch_done_o}), 32'(1 << d));
                chk("contend_rdata", 32'(rdata_o), 32'(d == PORT_DATA ? ref_mem[12'h003] : ref_mem[12'h002]));
                chk("contend_cycle", 32'(c % 4), 3);
                last_port = d;
                k++;
            end
        end
        chk("contend_count", 32'(k), 4);
        fetch_req_i = 1'b0; data_req_i = 1'b0;

        fetch_req_i = 1'b1; fetch_addr_i = 12'h000;
        n = 0;
        do begin @(negedge clk); n++; end while (!fetch_done_o && n < 10);
        chk("b2b_first_lat", 32'(n), 3);
        chk("b2b_first_data", 32'(rdata_o), 32'h1111);
        fetch_addr_i = 12'h001;
        n = 0;
        do begin @(negedge clk); n++; end while (!fetch_done_o && n < 10);
        chk("b2b_gap", 32'(n), 4);
        chk("b2b_second_data", 32'(rdata_o), 32'h5A5A);
        last_port = PORT_FETCH;
        fetch_req_i = 1'b0;
        @(negedge clk);

        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 12'h030; data_wdata_i = 16'hFFFF;
        @(negedge clk);
        chk("abort_in_issue", 32'(mem_en_o), 1);
        w0 = we_cnt;
        rst = 1'b1;
        #1;
        chk("abort_we_gated", 32'(mem_we_o), 0);
        data_req_i = 1'b0;
        @(negedge clk);
        chk("abort_reset_state", 32'({busy_o, grant_o, fetch_done_o, data_done_o, mem_en_o}), 0);
        rst = 1'b0;
        last_port = PORT_DATA;
        d = 0;
        repeat (5) begin
            @(negedge clk);
            d += int'(fetch_done_o) + int'(data_done_o);
        end
        chk("abort_no_done", 32'(d), 0);
        chk("abort_no_write", 32'(we_cnt - w0), 0);
        txn(1'b0, 12'h000, 1'b1, 1'b0, 12'h030, 16'h0000, PORT_DATA, 1'b1, 16'hA595);
        last_port = PORT_DATA;

        for (int i = 0; i < 40; i++) begin
            logic fr, dr;
            fr = 1'($urandom);
            dr = 1'($urandom);
            if (!fr && !dr) dr = 1'b1;
            model_txn(fr, 12'($urandom_range(12'h100, 12'h13F)), dr, 1'($urandom),
                      12'($urandom_range(12'h100, 12'h13F)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one synchronous single-port memory between the CPU's instruction-fetch path and its load/store data path. Sits between the `cpu` core and a single `memory` instance, replacing the separate instruction and data memories. Serialises accesses through a 4-state FSM, latches each winner's command, and returns a one-cycle done pulse with read data.

## Interface
- `N`, 16: data width; matches the CPU word.
- `AW`, 12: address width; matches the 12-bit immediate/address field.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `fetch_req_i`  in  1  fetch request; held until `fetch_done_o`
- `fetch_addr_i`  in  AW  fetch address; stable while `fetch_req_i`
- `fetch_done_o`  out  1  one-cycle completion pulse for fetch
- `data_req_i`  in  1  data request; held until `data_done_o`
- `data_we_i`  in  1  1 = store, 0 = load
- `data_addr_i`  in  AW  data address
- `data_wdata_i`  in  N  store data
- `data_done_o`  out  1  one-cycle completion pulse for data
- `rdata_o`  out  N  read data; valid only while a done pulse is high
- `grant_o`  out  2  one-hot owner: bit0 fetch, bit1 data
- `busy_o`  out  1  FSM not in IDLE
- `mem_en_o`, `mem_we_o`  out  1 each  memory enable/write enable
- `mem_addr_o`  out  AW;  `mem_wdata_o`  out  N
- `mem_rdata_i`  in  N  memory read data, one cycle after enable

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Transitions: IDLE→ISSUE when any request is high; ISSUE→WAIT; WAIT→DONE; DONE→IDLE unconditionally.
- IDLE: select winner, latch its address, write data, and write enable (fetch always latches we=0). `grant_o` is updated here.
- ISSUE: `mem_en_o`=1; address, write data, and write enable driven from the latch.
- WAIT: capture `mem_rdata_i` into the `rdata_o` register. For stores, `rdata_o` is the memory output as-is; requesters ignore it.
- DONE: winner's done bit is 1; `rdata_o` is valid. The requester drops or changes its request in the next cycle. A request still high in the following IDLE is a new transaction.
- Arbitration occurs only in IDLE. A request arriving mid-transaction waits.
- `grant_o` is one-hot from ISSUE through DONE and 0 in IDLE. `busy_o` = (state != IDLE).
- Tie-break without the macro: fixed priority, data over fetch. A load or store stalls fetch.
- Reset values: state IDLE; all done bits, `grant_o`, `busy_o`, `mem_en_o`, `mem_we_o` = 0; `rdata_o`, `mem_addr_o`, `mem_wdata_o` = 0; round-robin pointer = "data last granted".
- Reset mid-operation: the transaction is aborted and no done pulse is issued. `mem_we_o` is gated by `!rst`, so no write commits in a cycle with `rst` high.
- Address width: `mem_addr_o` is exactly AW bits. Requesters truncate wider addresses; no wrap logic lives here.

## Timing
- Request sampled high in IDLE at cycle T gives: ISSUE at T+1 (memory command), WAIT at T+2, done pulse and `rdata_o` at T+3, IDLE at T+4.
- Fixed latency is 3 cycles from grant to done; there is no back-pressure.
- Throughput is one access per 4 cycles. Back-to-back same-port requests complete at T+3, T+7, …
- Under continuous contention with round-robin, grants alternate, so each port completes once per 8 cycles.
- All outputs are registered except `mem_we_o` (state-decoded and `!rst`-gated).

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie, the port not granted last wins. The pointer updates on every grant, including uncontested ones.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, data over fetch. No pointer register exists.
- Single-request behaviour and latency are identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - port index constants `PORT_FETCH`=0 and `PORT_DATA`=1;
  - the FSM state enum `arb_state_t` {IDLE, ISSUE, WAIT, DONE};
  - defaults for N and AW.
- Sub-module `mem_arb_pick`: combinational 2-way picker. Inputs are the request vector and last-grant pointer; output is the one-hot winner. Its round-robin path is under the same macro.

## Test plan
- Reset: hold `rst` 2 cycles with both requests high. Required: all outputs 0 and no `mem_en_o`. The first grant occurs in the first cycle after `rst` falls.
- Single load: data_req, addr 0x010, memory holds 0xBEEF. Required: `mem_en_o` at T+1, `data_done_o` and `rdata_o`=0xBEEF at T+3, `busy_o` low at T+4.
- Store then fetch: store 0x1234 to 0x020, then fetch 0x020. Required: `mem_we_o` exactly 1 cycle, `fetch_done_o` with `rdata_o`=0x1234.
- Contention: both requests held high for 16 cycles. Required with macro: grant order data, fetch, data, fetch. Required without macro: data only, and fetch starves.
- Reset mid-transaction: assert `rst` during ISSUE of a store of 0xFFFF to 0x030. Required: no done pulse and address 0x030 unchanged.
- Back-to-back fetch: hold fetch_req for addresses 0x000 then 0x001. Required: done pulses 4 cycles apart with correct data.
